// File: rtl/times_table_sequencer_if.sv
// Handshake and data bundle between the times-table sequencer, its multiplier datapath and the consumer.
// master = sequencer side; slave = datapath/consumer/controller side.
interface times_table_sequencer_if;
  logic       start;
  logic [2:0] tt_a;
  logic [2:0] tt_b;
  logic       tt_enable;
  logic [5:0] tt_result;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_a;
  logic [2:0] out_b;
  logic [5:0] out_product;
  logic       busy;
  logic       done;
  logic       err;
  logic [6:0] pair_count;

  modport master (
    input  start, tt_result, out_ready,
    output tt_a, tt_b, tt_enable, out_valid, out_a, out_b, out_product,
           busy, done, err, pair_count
  );

  modport slave (
    output start, tt_result, out_ready,
    input  tt_a, tt_b, tt_enable, out_valid, out_a, out_b, out_product,
           busy, done, err, pair_count
  );
endinterface

// File: rtl/times_table_sequencer.sv
// Sweeps every (a,b) operand pair through an external multiplier, checks each product and presents it downstream.
// One op in flight, DP_LATENCY+2 cycles per entry at full rate; out_ready low parks the entry in OUT unchanged.
module times_table_sequencer #(
  parameter int DP_LATENCY  = 1,
  parameter int MAX_OPERAND = 7
) (
  input logic                     clk,
  input logic                     rst_n,
  times_table_sequencer_if.master tt
);
  localparam logic [2:0] MAX_OP   = 3'(MAX_OPERAND);
  localparam logic [1:0] LAT_LAST = 2'(DP_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT,
    S_FINISH
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] a_q, a_d;
  logic [2:0] b_q, b_d;
  logic [1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0] out_a_q, out_a_d;
  logic [2:0] out_b_q, out_b_d;
  logic [5:0] out_product_q, out_product_d;
  logic       err_q, err_d;
  logic [6:0] pair_count_q, pair_count_d;
  logic [5:0] exp_product;

  // 3x3-bit operands never exceed 49, so the 6-bit product is exact.
  assign exp_product = {3'b000, a_q} * {3'b000, b_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      wait_cnt_q    <= '0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_product_q <= '0;
      err_q         <= 1'b0;
      pair_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      wait_cnt_q    <= wait_cnt_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_product_q <= out_product_d;
      err_q         <= err_d;
      pair_count_q  <= pair_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    wait_cnt_d    = wait_cnt_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_product_d = out_product_q;
    err_d         = err_q;
    pair_count_d  = pair_count_q;

    case (state_q)
      S_IDLE: begin
        if (tt.start) begin
          state_d      = S_ISSUE;
          a_d          = '0;
          b_d          = '0;
          pair_count_d = '0;
          err_d        = 1'b0;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == LAT_LAST) begin
          out_product_d = tt.tt_result;
          out_a_d       = a_q;
          out_b_d       = b_q;
          // A bad product is flagged but the sweep still runs to completion.
          if (tt.tt_result != exp_product) begin
            err_d = 1'b1;
          end
          state_d = S_OUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      S_OUT: begin
        if (tt.out_ready) begin
          pair_count_d = pair_count_q + 7'd1;
          if ((a_q == MAX_OP) && (b_q == MAX_OP)) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_ISSUE;
            if (b_q == MAX_OP) begin
              b_d = '0;
              a_d = a_q + 3'd1;
            end else begin
              b_d = b_q + 3'd1;
            end
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tt.tt_a        = a_q;
  assign tt.tt_b        = b_q;
  assign tt.tt_enable   = (state_q == S_ISSUE);
  assign tt.out_valid   = (state_q == S_OUT);
  assign tt.out_a       = out_a_q;
  assign tt.out_b       = out_b_q;
  assign tt.out_product = out_product_q;
  assign tt.busy        = (state_q != S_IDLE);
  assign tt.done        = (state_q == S_FINISH);
  assign tt.err         = err_q;
  assign tt.pair_count  = pair_count_q;

endmodule

// File: doc/times_table_sequencer.md
TIMES_TABLE_SEQUENCER -- requirements
Module: times_table_sequencer

Interface
REQ-001 Parameter DP_LATENCY, default 1, meaning cycles from tt_enable to valid tt_result (legal 1..3).
REQ-002 Parameter MAX_OPERAND, default 7, meaning last operand value swept for both a and b (legal 1..7).
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin sweep, sampled in IDLE only.
REQ-006 tt_a  output  3  operand a to times-table datapath.
REQ-007 tt_b  output  3  operand b to times-table datapath.
REQ-008 tt_enable  output  1  one-cycle issue strobe to datapath.
REQ-009 tt_result  input  6  datapath product, valid DP_LATENCY cycles after tt_enable.
REQ-010 out_valid  output  1  captured entry available.
REQ-011 out_ready  input  1  downstream accepts entry.
REQ-012 out_a, out_b  output  3 each  operands of presented entry.
REQ-013 out_product  output  6  captured tt_result of presented entry.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 done  output  1  one-cycle pulse at end of sweep.
REQ-016 err  output  1  sticky mismatch flag.
REQ-017 pair_count  output  7  entries accepted downstream this sweep.

Function
REQ-018 States IDLE, ISSUE, WAIT, OUT, FINISH; encoding free.
REQ-019 IDLE: start=1 -> ISSUE next cycle, operands a=b=0, pair_count=0, err cleared; start=0 -> stay.
REQ-020 ISSUE: tt_enable=1 for exactly one cycle with tt_a/tt_b = current a/b -> WAIT.
REQ-021 WAIT: count DP_LATENCY cycles after ISSUE; on final count capture tt_result into out_product, a/b into out_a/out_b -> OUT.
REQ-022 tt_enable SHALL be 0 in every state except ISSUE; at most one operation in flight.
REQ-023 OUT: out_valid=1; entry fields stable while out_valid=1 and out_ready=0.
REQ-024 OUT with out_ready=1: transfer, pair_count+1, then advance: b+1; if b==MAX_OPERAND, b=0 and a+1; if a==b==MAX_OPERAND -> FINISH, else -> ISSUE.
REQ-025 FINISH: done=1 one cycle -> IDLE; busy falls in same cycle as entering IDLE.
REQ-026 Capture check: if captured tt_result != a*b (6-bit, exact), err set and held until next accepted start or reset; sweep continues.
REQ-027 start while busy SHALL be ignored; no restart, no err clear.
REQ-028 out_ready outside OUT SHALL be ignored.
REQ-029 Full sweep with out_ready tied 1 SHALL take exactly (MAX_OPERAND+1)^2 * (DP_LATENCY+2) + 1 cycles from start sample to done.
REQ-030 pair_count SHALL hold final value after done until next accepted start.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, tt_enable=0, out_valid=0, done=0, busy=0, err=0, pair_count=0, tt_a=tt_b=out_a=out_b=0, out_product=0, regardless of state.
REQ-032 After rst_n rises, no activity until start=1 sampled in IDLE; a reset mid-sweep SHALL NOT resume the old sweep.

Verification
REQ-033 Defaults, ideal datapath (result = a*b, 1-cycle), out_ready=1, start pulse -> 64 entries in order (0,0),(0,1)..(7,7), last out_product=49, done after 193 cycles, pair_count=64, err=0.
REQ-034 Backpressure: out_ready low 5 cycles at entry (3,4) -> out_valid held, out_a=3, out_b=4, out_product=12 stable, tt_enable stays 0, entry accepted once when out_ready rises.
REQ-035 Faulty datapath returns 20 for (4,4) -> err rises at capture and stays 1 through done; next start clears err to 0.
REQ-036 DP_LATENCY=3, MAX_OPERAND=2 -> 9 entries, (2,2) product 4, done 46 cycles after start sample.
REQ-037 rst_n low at entry (5,2) mid-WAIT -> all outputs zero asynchronously; after release, start gives first entry (0,0).
REQ-038 start re-pulsed at entry (1,1) while busy -> no effect; sequence continues to (1,2), pair_count unaffected.
